// File: rtl/mem_pkg.sv
// mem_pkg: FSM state encoding, funct3 access-size constants and lane helpers shared by mem_lsu.
package mem_pkg;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Size comes from funct3[1:0]; every code that is neither byte nor half is a word.
   function automatic logic is_byte(input logic [2:0] f3);
      return f3[1:0] == F3_B[1:0];
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return f3[1:0] == F3_H[1:0] && F3_HU[1:0] == F3_H[1:0];
   endfunction

   function automatic logic is_unsigned(input logic [2:0] f3);
      return f3[2] == F3_BU[2];
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
      return is_byte(f3) ? 4'b0001 << a : is_half(f3) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      return is_byte(f3) ? 1'b0 : is_half(f3) ? a[0] : (a != 2'b00 && f3[1] == F3_W[1]);
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: picks the byte/halfword lane of a load word and sign- or zero-extends it.
module mem_load_ext
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;
   logic        sx;

   assign b    = rdata[{addr_lo, 3'b000} +: 8];
   assign h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   assign sx   = !is_unsigned(funct3);
   assign data = is_byte(funct3) ? {{24{sx & b[7]}}, b}
               : is_half(funct3) ? {{16{sx & h[15]}}, h}
               : rdata;

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a req/gnt/rvalid data bus and WAIT timeout.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_lsu
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        bus_err,
   output logic        misalign
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   state_t        state, state_d;
   logic [31:0]   addr_q, sdata_q, ld_data;
   logic [2:0]    f3_q;
   logic [4:0]    rd_q;
   logic          we_q;
   logic [CW-1:0] cnt;
   logic          accept, mem_op, trap, timeout;

   assign accept  = state == S_IDLE && ex_valid;
   assign mem_op  = mem_read | mem_write;
   assign timeout = state == S_WAIT && !dmem_rvalid && cnt == CW'(TIMEOUT_CYC - 1);

`ifdef MEM_MISALIGN_TRAP_EN
   logic mis_q;
   assign trap     = misaligned(funct3, alu_result[1:0]);
   assign misalign = mis_q;
   always_ff @(posedge clk) begin
      if (rst) mis_q <= 1'b0;
      else mis_q <= accept && mem_op && trap;
   end
`else
   assign trap     = 1'b0;
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  state_d = (accept && mem_op && !trap) ? S_REQ : S_IDLE;
         S_REQ:   state_d = !dmem_gnt ? S_REQ : we_q ? S_IDLE : S_WAIT;
         S_WAIT:  state_d = (dmem_rvalid || timeout) ? S_IDLE : S_WAIT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         sdata_q  <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         we_q     <= 1'b0;
         cnt      <= '0;
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         bus_err  <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= (state == S_WAIT) ? cnt + 1'b1 : '0;
         wb_valid <= 1'b0;
         bus_err  <= timeout;
         if (accept && mem_op) begin
            addr_q  <= alu_result;
            sdata_q <= store_data;
            f3_q    <= funct3;
            rd_q    <= rd;
            we_q    <= mem_write;
         end else if (accept) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd;
            wb_data  <= alu_result;
         end
         if (state == S_WAIT && dmem_rvalid) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= ld_data;
         end
      end
   end

   mem_load_ext u_ext (
      .rdata   (dmem_rdata),
      .addr_lo (addr_q[1:0]),
      .funct3  (f3_q),
      .data    (ld_data)
   );

   assign stall      = state != S_IDLE;
   assign dmem_req   = state == S_REQ;
   assign dmem_we    = dmem_req & we_q;
   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_be    = dmem_req ? byte_en(f3_q, addr_q[1:0]) : 4'b0000;
   assign dmem_wdata = is_byte(f3_q) ? {4{sdata_q[7:0]}}
                     : is_half(f3_q) ? {2{sdata_q[15:0]}}
                     : sdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed stimulus with a scoreboard of expected wb/bus_err/misalign events.
module tb_mem_lsu;

   typedef struct packed {
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [31:0] data;
   } ev_t;

   logic        clk = 0, rst = 1;
   logic        ex_valid = 0, mem_read = 0, mem_write = 0;
   logic [2:0]  funct3 = 0;
   logic [31:0] alu_result = 0, store_data = 0;
   logic [4:0]  rd = 0;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt = 0, dmem_rvalid = 0;
   logic [31:0] dmem_rdata = 0;
   logic        wb_valid, bus_err, misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0, errors = 0;
   ev_t sb[$];

   mem_lsu #(.TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .alu_result(alu_result), .store_data(store_data), .rd(rd),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_data(wb_data), .bus_err(bus_err), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wb_valid || bus_err || misalign) begin
         ev_t e;
         logic [1:0] k;
         k = wb_valid ? 2'd0 : bus_err ? 2'd1 : 2'd2;
         checks++;
         if (int'(wb_valid) + int'(bus_err) + int'(misalign) > 1) begin
            errors++;
            $display("FAIL exclusive: wb_valid=%b bus_err=%b misalign=%b", wb_valid, bus_err, misalign);
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected event: kind %0d rd %0d data 0x%08h", k, wb_rd, wb_data);
         end else begin
            e = sb.pop_front();
            if (k !== e.kind || (k == 0 && (wb_rd !== e.rd || wb_data !== e.data))) begin
               errors++;
               $display("FAIL event: got kind %0d rd %0d data 0x%08h want kind %0d rd %0d data 0x%08h",
                        k, wb_rd, wb_data, e.kind, e.rd, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
      ex_valid = 1; mem_read = mr; mem_write = mw; funct3 = f3;
      alu_result = a; store_data = sd; rd = r;
      step();
      ex_valid = 0; mem_read = 0; mem_write = 0;
   endtask

   // Hold off gnt for gd cycles, checking the request stays stable, then grant.
   task automatic bus(input string name, input int gd, input logic [31:0] ea, input logic [3:0] ebe,
                      input logic ewe, input logic [31:0] ewd);
      for (int i = 0; i <= gd; i++) begin
         check({name, " req"}, 32'(dmem_req), 32'd1);
         check({name, " addr"}, dmem_addr, ea);
         check({name, " be"}, 32'(dmem_be), 32'(ebe));
         check({name, " we"}, 32'(dmem_we), 32'(ewe));
         if (ewe) check({name, " wdata"}, dmem_wdata, ewd);
         if (i == gd) dmem_gnt = 1;
         step();
      end
      dmem_gnt = 0;
      check({name, " req dropped"}, 32'(dmem_req), 32'd0);
   endtask

   task automatic rvalid(input int d, input logic [31:0] data);
      repeat (d) step();
      check("wait stall", 32'(stall), 32'd1);
      dmem_rvalid = 1; dmem_rdata = data;
      step();
      dmem_rvalid = 0; dmem_rdata = 0;
   endtask

   task automatic load(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                       input logic [31:0] rdata, input logic [3:0] ebe, input logic [31:0] exp);
      sb.push_back('{2'd0, r, exp});
      issue(1, 0, f3, a, 0, r);
      bus(name, 0, {a[31:2], 2'b00}, ebe, 0, 0);
      rvalid(0, rdata);
      check({name, " wb_valid"}, 32'(wb_valid), 32'd1);
   endtask

   initial begin
      repeat (2) step();
      check("rst stall", 32'(stall), 0);
      check("rst req", 32'(dmem_req), 0);
      check("rst we", 32'(dmem_we), 0);
      check("rst be", 32'(dmem_be), 0);
      check("rst addr", dmem_addr, 0);
      check("rst wb_valid", 32'(wb_valid), 0);
      check("rst bus_err", 32'(bus_err), 0);
      check("rst misalign", 32'(misalign), 0);
      rst = 0;
      dmem_rvalid = 1;
      step();
      dmem_rvalid = 0;

      sb.push_back('{2'd0, 5'd5, 32'h1234});
      issue(0, 0, 3'b000, 32'h1234, 0, 5'd5);
      check("alu stall", 32'(stall), 0);
      check("alu wb_valid", 32'(wb_valid), 1);
      step();

      issue(0, 1, 3'b000, 32'h103, 32'hAB, 5'd1);
      bus("sb", 1, 32'h100, 4'b1000, 1, 32'hABABABAB);
      check("sb stall", 32'(stall), 0);
      issue(0, 1, 3'b001, 32'h102, 32'h1234CAFE, 5'd1);
      bus("sh", 0, 32'h100, 4'b1100, 1, 32'hCAFECAFE);
      issue(1, 1, 3'b010, 32'h200, 32'hDEADBEEF, 5'd2);
      bus("sw both", 2, 32'h200, 4'b1111, 1, 32'hDEADBEEF);
      step();

      load("lb", 3'b000, 32'h2, 5'd3, 32'h00800000, 4'b0100, 32'hFFFFFF80);
      load("lbu", 3'b100, 32'h2, 5'd4, 32'h00800000, 4'b0100, 32'h00000080);
      load("lhu", 3'b101, 32'h2, 5'd6, 32'hBEEF0000, 4'b1100, 32'h0000BEEF);
      load("lh", 3'b001, 32'h0, 5'd7, 32'h12348001, 4'b0011, 32'hFFFF8001);
      load("f3 011", 3'b011, 32'h4, 5'd9, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF);

      sb.push_back('{2'd0, 5'd8, 32'hCAFEF00D});
      issue(1, 0, 3'b010, 32'h8, 0, 5'd8);
      bus("lw", 1, 32'h8, 4'b1111, 0, 0);
      rvalid(2, 32'hCAFEF00D);
      step();

      sb.push_back('{2'd1, 5'd0, 32'h0});
      issue(1, 0, 3'b010, 32'h10, 0, 5'd10);
      bus("lw timeout", 0, 32'h10, 4'b1111, 0, 0);
      begin
         int k;
         k = 0;
         for (int i = 1; i <= 10 && k == 0; i++) begin
            step();
            if (bus_err) k = i;
         end
         check("bus_err latency", 32'(k), 32'd4);
      end
      check("timeout stall", 32'(stall), 0);
      step();

      issue(1, 0, 3'b010, 32'h20, 0, 5'd11);
      bus("lw rst", 0, 32'h20, 4'b1111, 0, 0);
      step();
      rst = 1;
      step();
      rst = 0;
      dmem_rvalid = 1; dmem_rdata = 32'h55;
      step();
      dmem_rvalid = 0;
      check("abandon stall", 32'(stall), 0);
      check("abandon req", 32'(dmem_req), 0);
      check("abandon be", 32'(dmem_be), 0);
      check("abandon wb_valid", 32'(wb_valid), 0);
      check("abandon addr", dmem_addr, 0);
      step();

`ifdef MEM_MISALIGN_TRAP_EN
      sb.push_back('{2'd2, 5'd0, 32'h0});
      issue(1, 0, 3'b010, 32'h6, 0, 5'd12);
      check("mis pulse", 32'(misalign), 1);
      for (int i = 0; i < 4; i++) begin
         check("mis no req", 32'(dmem_req), 0);
         check("mis stall", 32'(stall), 0);
         step();
      end
`else
      load("lw 0x6", 3'b010, 32'h6, 5'd12, 32'h01020304, 4'b1111, 32'h01020304);
`endif

      repeat (3) step();
      check("scoreboard drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
